// File: rtl/lcdg_pkg.sv
// Shared types and constants for the KS0108-type graphic LCD bus writer.
package lcdg_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD = 3'd0,
        ST_BOOT     = 3'd1,
        ST_IDLE     = 3'd2,
        ST_SETUP    = 3'd3,
        ST_EN_HI    = 3'd4,
        ST_EN_LO    = 3'd5,
        ST_GAP      = 3'd6
    } lcdg_state_e;

    localparam int unsigned STATUS_BUSY_BIT  = 7;
    localparam int unsigned STATUS_RESET_BIT = 4;

    localparam logic [1:0] CS_NONE  = 2'b00;
    localparam logic [1:0] CS_LEFT  = 2'b01;
    localparam logic [1:0] CS_RIGHT = 2'b10;
    localparam logic [1:0] CS_BOTH  = 2'b11;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Bits needed to hold (v-1); never less than one.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/lcdg_timer.sv
// Loadable down-counter with a zero flag; times every state of the bus writer.
module lcdg_timer #(
    parameter int unsigned    W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/lcdg_bus_writer.sv
// Automatic write master for the dual-controller 128x64 KS0108-type LCD bus.
// Optional busy-flag polling after each write: define LCDG_BUSY_POLL_EN.
module lcdg_bus_writer
    import lcdg_pkg::*;
#(
    parameter int unsigned T_RST    = 50000,
    parameter int unsigned T_BOOT   = 500000,
    parameter int unsigned T_SETUP  = 4,
    parameter int unsigned T_EN_HI  = 25,
    parameter int unsigned T_EN_LO  = 25,
    parameter int unsigned T_GAP    = 250,
    parameter int unsigned POLL_MAX = 1023
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_di,
    input  logic [1:0] req_cs,
    input  logic [7:0] req_data,
    output logic       init_done,
    output logic       poll_timeout,
    output logic [7:0] db_o,
    output logic       db_oe,
    input  logic [7:0] db_i,
    output logic       dori_o,
    output logic       rw_o,
    output logic       en_o,
    output logic       cs1_o,
    output logic       cs2_o,
    output logic       rst_o
);

    localparam int unsigned T_MAX = max_u(max_u(max_u(T_RST, T_BOOT), max_u(T_SETUP, T_EN_HI)),
                                          max_u(T_EN_LO, T_GAP));
    localparam int unsigned CW    = cnt_width(T_MAX);

    lcdg_state_e r_state, w_state_nxt;

    logic          w_zero_c;
    logic          w_load;
    logic [CW-1:0] w_load_val;

    logic       r_req_ready, r_init_done, r_poll_timeout, r_db_oe, r_dori, r_rw, r_en;
    logic       r_cs1, r_cs2, r_rst;
    logic [7:0] r_db_o;

    logic       w_req_ready_nxt, w_init_done_nxt, w_timeout_nxt, w_db_oe_nxt, w_dori_nxt;
    logic       w_rw_nxt, w_en_nxt, w_cs1_nxt, w_cs2_nxt, w_rst_nxt;
    logic [7:0] w_db_nxt;

    logic w_unused;

`ifdef LCDG_BUSY_POLL_EN
    localparam int unsigned PW = cnt_width(POLL_MAX + 1);

    logic          r_polling, w_polling_nxt;
    logic          r_busy, w_busy_nxt;
    logic [PW-1:0] r_poll_cnt, w_poll_cnt_nxt;

    assign w_unused = ^{db_i[6:0]};
`else
    assign w_unused = ^{db_i, 32'(POLL_MAX)};
`endif

    // Counter reload value for a state being entered: duration minus one.
    function automatic logic [CW-1:0] load_for(input lcdg_state_e s);
        logic [CW-1:0] v;
        case (s)
            ST_RST_HOLD: v = CW'(T_RST - 1);
            ST_BOOT:     v = CW'(T_BOOT - 1);
            ST_SETUP:    v = CW'(T_SETUP - 1);
            ST_EN_HI:    v = CW'(T_EN_HI - 1);
            ST_EN_LO:    v = CW'(T_EN_LO - 1);
            ST_GAP:      v = CW'(T_GAP - 1);
            default:     v = '0;
        endcase
        return v;
    endfunction

    lcdg_timer #(
        .W       (CW),
        .RST_VAL (CW'(T_RST - 1))
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero_c   (w_zero_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= ST_RST_HOLD;
            r_req_ready    <= 1'b0;
            r_init_done    <= 1'b0;
            r_poll_timeout <= 1'b0;
            r_db_o         <= 8'h00;
            r_db_oe        <= 1'b0;
            r_dori         <= 1'b0;
            r_rw           <= 1'b0;
            r_en           <= 1'b0;
            r_cs1          <= 1'b0;
            r_cs2          <= 1'b0;
            r_rst          <= 1'b0;
`ifdef LCDG_BUSY_POLL_EN
            r_polling      <= 1'b0;
            r_busy         <= 1'b0;
            r_poll_cnt     <= '0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_req_ready    <= w_req_ready_nxt;
            r_init_done    <= w_init_done_nxt;
            r_poll_timeout <= w_timeout_nxt;
            r_db_o         <= w_db_nxt;
            r_db_oe        <= w_db_oe_nxt;
            r_dori         <= w_dori_nxt;
            r_rw           <= w_rw_nxt;
            r_en           <= w_en_nxt;
            r_cs1          <= w_cs1_nxt;
            r_cs2          <= w_cs2_nxt;
            r_rst          <= w_rst_nxt;
`ifdef LCDG_BUSY_POLL_EN
            r_polling      <= w_polling_nxt;
            r_busy         <= w_busy_nxt;
            r_poll_cnt     <= w_poll_cnt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_db_nxt      = r_db_o;
        w_db_oe_nxt   = r_db_oe;
        w_dori_nxt    = r_dori;
        w_rw_nxt      = r_rw;
        w_cs1_nxt     = r_cs1;
        w_cs2_nxt     = r_cs2;
        w_timeout_nxt = 1'b0;
`ifdef LCDG_BUSY_POLL_EN
        w_polling_nxt  = r_polling;
        w_busy_nxt     = r_busy;
        w_poll_cnt_nxt = r_poll_cnt;
`endif

        case (r_state)
            ST_RST_HOLD: if (w_zero_c) w_state_nxt = ST_BOOT;
            ST_BOOT:     if (w_zero_c) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_state_nxt = ST_SETUP;
                    w_db_nxt    = req_data;
                    w_db_oe_nxt = 1'b1;
                    w_dori_nxt  = req_di;
                    w_rw_nxt    = 1'b0;
                    w_cs1_nxt   = req_cs[0];
                    w_cs2_nxt   = req_cs[1];
`ifdef LCDG_BUSY_POLL_EN
                    w_polling_nxt = 1'b0;
`endif
                end
            end
            ST_SETUP: begin
                if (w_zero_c) begin
                    w_state_nxt = ST_EN_HI;
`ifdef LCDG_BUSY_POLL_EN
                    if (r_polling) w_poll_cnt_nxt = r_poll_cnt + PW'(1);
`endif
                end
            end
            ST_EN_HI: begin
                if (w_zero_c) begin
                    w_state_nxt = ST_EN_LO;
`ifdef LCDG_BUSY_POLL_EN
                    if (r_polling) w_busy_nxt = db_i[STATUS_BUSY_BIT];
`endif
                end
            end
            ST_EN_LO: begin
                if (w_zero_c) begin
`ifdef LCDG_BUSY_POLL_EN
                    if (!r_polling) begin
                        // Write done: turn the bus around for status reads of one chip.
                        if (r_cs1 || r_cs2) begin
                            w_state_nxt    = ST_SETUP;
                            w_rw_nxt       = 1'b1;
                            w_dori_nxt     = 1'b0;
                            w_db_oe_nxt    = 1'b0;
                            w_cs1_nxt      = r_cs1;
                            w_cs2_nxt      = !r_cs1;
                            w_polling_nxt  = 1'b1;
                            w_poll_cnt_nxt = '0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_db_oe_nxt = 1'b0;
                        end
                    end else if (r_busy && (r_poll_cnt < PW'(POLL_MAX))) begin
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_nxt = r_busy;
                        w_cs1_nxt     = 1'b0;
                        w_cs2_nxt     = 1'b0;
                        w_rw_nxt      = 1'b0;
                        w_polling_nxt = 1'b0;
                    end
`else
                    w_state_nxt = ST_GAP;
                    w_cs1_nxt   = 1'b0;
                    w_cs2_nxt   = 1'b0;
                    w_db_oe_nxt = 1'b0;
`endif
                end
            end
            ST_GAP:  if (w_zero_c) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_RST_HOLD;
        endcase

        w_load          = (w_state_nxt != r_state);
        w_load_val      = load_for(w_state_nxt);
        w_rst_nxt       = (w_state_nxt != ST_RST_HOLD);
        w_init_done_nxt = r_init_done || (w_state_nxt == ST_IDLE);
        w_req_ready_nxt = (w_state_nxt == ST_IDLE);
        w_en_nxt        = (w_state_nxt == ST_EN_HI);
    end

    assign req_ready    = r_req_ready;
    assign init_done    = r_init_done;
    assign poll_timeout = r_poll_timeout;
    assign db_o         = r_db_o;
    assign db_oe        = r_db_oe;
    assign dori_o       = r_dori;
    assign rw_o         = r_rw;
    assign en_o         = r_en;
    assign cs1_o        = r_cs1;
    assign cs2_o        = r_cs2;
    assign rst_o        = r_rst;

endmodule

// File: tb/tb_lcdg_bus_writer.sv
// Directed bench for lcdg_bus_writer with shortened reset/boot times.
module tb_lcdg_bus_writer;

    localparam int unsigned P_RST  = 20;
    localparam int unsigned P_BOOT = 60;
    localparam int          BOUND  = 1000;

    localparam int SIG_RST   = 0;
    localparam int SIG_INIT  = 1;
    localparam int SIG_READY = 2;
    localparam int SIG_EN    = 3;
    localparam int SIG_CS1   = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_valid;
    logic       req_ready;
    logic       req_di;
    logic [1:0] req_cs;
    logic [7:0] req_data;
    logic       init_done;
    logic       poll_timeout;
    logic [7:0] db_o;
    logic       db_oe;
    logic [7:0] db_i;
    logic       dori_o;
    logic       rw_o;
    logic       en_o;
    logic       cs1_o;
    logic       cs2_o;
    logic       rst_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int en_rises = 0;
    logic en_d   = 1'b0;

    always #5 clk = ~clk;

    lcdg_bus_writer #(
        .T_RST  (P_RST),
        .T_BOOT (P_BOOT)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_di       (req_di),
        .req_cs       (req_cs),
        .req_data     (req_data),
        .init_done    (init_done),
        .poll_timeout (poll_timeout),
        .db_o         (db_o),
        .db_oe        (db_oe),
        .db_i         (db_i),
        .dori_o       (dori_o),
        .rw_o         (rw_o),
        .en_o         (en_o),
        .cs1_o        (cs1_o),
        .cs2_o        (cs2_o),
        .rst_o        (rst_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en_o && !en_d) en_rises <= en_rises + 1;
        en_d <= en_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            SIG_RST:   return rst_o;
            SIG_INIT:  return init_done;
            SIG_READY: return req_ready;
            SIG_EN:    return en_o;
            SIG_CS1:   return cs1_o;
            default:   return 1'bx;
        endcase
    endfunction

    // Count rising clock edges until the selected output reaches val (bounded).
    task automatic edges_until(input int which, input logic val, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sel(which) !== val) && (n < BOUND));
    endtask

    initial begin
        int n;
        int total;
        int e0;
        int rise1;
        int rise2;

        rstn      = 1'b0;
        req_valid = 1'b0;
        req_di    = 1'b0;
        req_cs    = 2'b00;
        req_data  = 8'h00;
        db_i      = 8'h00;

        // Reset values and power-up sequence
        repeat (3) @(negedge clk);
        chk("rst_rst_o", rst_o, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_init", init_done, 0);
        chk("rst_oe_en", {db_oe, en_o, cs1_o, cs2_o, poll_timeout}, 0);
        rstn = 1'b1;
        edges_until(SIG_RST, 1'b1, n);
        chk("t_rst", n, P_RST);
        chk("init_during_boot", init_done, 0);
        edges_until(SIG_INIT, 1'b1, n);
        chk("t_boot", n, P_BOOT);
        chk("ready_after_boot", req_ready, 1);

        // Instruction write to the left half
        @(negedge clk);
        chk("w1_ready", req_ready, 1);
        req_valid = 1'b1; req_di = 1'b0; req_cs = 2'b01; req_data = 8'h3F;
        @(posedge clk); #1;
        chk("w1_db", db_o, 8'h3F);
        chk("w1_pins", {db_oe, rw_o, dori_o, cs2_o, cs1_o, en_o, req_ready}, 7'b1000100);
        req_valid = 1'b0; req_di = 1'b1; req_cs = 2'b10; req_data = 8'h00;
        total = 1;
        edges_until(SIG_EN, 1'b1, n);
        chk("w1_setup", n, 4); total += n;
        chk("w1_bus_en", {db_o, cs2_o, cs1_o, rw_o, dori_o}, {8'h3F, 4'b0100});
        edges_until(SIG_EN, 1'b0, n);
        chk("w1_en_hi", n, 25); total += n;
        chk("w1_hold_lo", {db_o, cs1_o, db_oe}, {8'h3F, 2'b11});
        edges_until(SIG_CS1, 1'b0, n);
        chk("w1_en_lo", n, 25); total += n;
        chk("w1_gap_oe", db_oe, 0);
        edges_until(SIG_READY, 1'b1, n);
        chk("w1_gap", n, 250); total += n;
        chk("w1_latency", total, 305);

        // Broadcast data write: both chips selected, one enable pulse
        e0 = en_rises;
        @(negedge clk);
        req_valid = 1'b1; req_di = 1'b1; req_cs = 2'b11; req_data = 8'hA5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bc_bus", {db_o, dori_o, cs2_o, cs1_o}, {8'hA5, 3'b111});
        edges_until(SIG_EN, 1'b1, n);
        chk("bc_cs_en", {cs2_o, cs1_o, en_o}, 3'b111);
        edges_until(SIG_READY, 1'b1, n);
        chk("bc_to_ready", n, 300);
        @(negedge clk);
        chk("bc_en_pulses", en_rises - e0, 1);

        // No chip selected still runs a full cycle
        req_valid = 1'b1; req_di = 1'b0; req_cs = 2'b00; req_data = 8'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        edges_until(SIG_EN, 1'b1, n);
        chk("cs00_setup", n, 4);
        chk("cs00_cs", {cs2_o, cs1_o}, 2'b00);
        edges_until(SIG_READY, 1'b1, n);
        chk("cs00_to_ready", n, 300);

        // Back-to-back: valid held, second byte waits for the gap
        @(negedge clk);
        req_valid = 1'b1; req_di = 1'b1; req_cs = 2'b10; req_data = 8'h11;
        @(posedge clk); #1;
        chk("b2b_first_db", db_o, 8'h11);
        @(negedge clk);
        req_cs = 2'b01; req_data = 8'h22;
        edges_until(SIG_EN, 1'b1, n);
        rise1 = cyc;
        chk("b2b_first_bus", {db_o, cs2_o, cs1_o}, {8'h11, 2'b10});
        edges_until(SIG_READY, 1'b1, n);
        chk("b2b_en_to_ready", n, 300);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b_second_acc", {req_ready, db_o, cs2_o, cs1_o}, {1'b0, 8'h22, 2'b01});
        edges_until(SIG_EN, 1'b1, n);
        rise2 = cyc;
        chk("b2b_sep", rise2 - rise1, 305);
        edges_until(SIG_READY, 1'b1, n);
        chk("b2b_second_done", n, 300);

        // Asynchronous reset in the middle of the enable pulse
        @(negedge clk);
        req_valid = 1'b1; req_di = 1'b0; req_cs = 2'b01; req_data = 8'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        edges_until(SIG_EN, 1'b1, n);
        repeat (3) @(posedge clk);
        #3;
        chk("ar_en_before", en_o, 1);
        rstn = 1'b0;
        #1;
        chk("ar_en_rst", {en_o, rst_o}, 2'b00);
        chk("ar_others", {init_done, req_ready, db_oe, cs1_o, db_o}, 12'h000);
        repeat (2) @(negedge clk);
        chk("ar_held", {rst_o, en_o}, 2'b00);
        rstn = 1'b1;
        edges_until(SIG_RST, 1'b1, n);
        chk("ar_t_rst", n, P_RST);
        edges_until(SIG_INIT, 1'b1, n);
        chk("ar_t_boot", n, P_BOOT);
        chk("ar_ready", {req_ready, poll_timeout}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
